// File: rtl/serial_add_sub_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_sub_if
// Description : Handshake bundle for the bit-serial adder/subtractor.
//               Operand side: in_valid/in_ready with op_sub, a, b.
//               Result side : out_valid/out_ready with result, cout,
//                             overflow, zero.
//               master = producer of operands / consumer of results,
//               slave  = the serial_add_sub block.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero
  );
endinterface
`default_nettype wire

// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_sub
// Description : Bit-serial two's-complement adder/subtractor. One full-adder
//               cell plus a carry flop processes one bit per clock, LSB first.
//               Operation accepted at edge T finishes at edge T+WIDTH;
//               out_valid is high from then until the result is taken.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - serial_add_sub_if.slave (operand and result
//                       valid/ready handshakes, result flags)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  serial_add_sub_if.slave bus
);

  localparam int                 CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  // Holds the first WIDTH-1 sum bits; the last bit is never stored here,
  // it goes straight into the result on the final edge.
  logic [WIDTH-2:0] r_sh;

  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;

  logic             w_sum;
  logic             w_carry_next;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_res;

  // Full-adder cell on the current LSBs.
  assign w_sum        = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry_next = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last       = (r_cnt == C_LAST);
  assign w_accept     = (r_state == IDLE) && bus.in_valid;
  assign w_res        = {w_sum, r_sh};

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;
  assign bus.overflow  = r_overflow;
  assign bus.zero      = r_zero;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (bus.in_valid)  w_state_next = RUN;
      RUN:  if (w_last)        w_state_next = DONE;
      DONE: if (bus.out_ready) w_state_next = IDLE;
      default:                 w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand shift registers, carry flop, result assembly
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_sh       <= '0;
      r_result   <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
      r_a     <= bus.a;
      r_b     <= bus.op_sub ? ~bus.b : bus.b;
      r_carry <= bus.op_sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_carry_next;
      r_sh    <= w_res[WIDTH-1:1];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        // r_carry is the carry into the MSB cell at this point.
        r_result   <= w_res;
        r_cout     <= w_carry_next;
        r_overflow <= r_carry ^ w_carry_next;
        r_zero     <= (w_res == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial two's-complement adder/subtractor. It processes one bit per clock, LSB first, through a single full-adder cell and a carry flop.
- It complements the combinational ripple adder path. It trades area for latency in places where a WIDTH-bit ripple chain is too large.
- Operands arrive on a valid/ready input handshake. The result and flags leave on a valid/ready output handshake.
- It handles one operation at a time, with no overlap.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range is 2 to 64.

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  operands and op_sub are valid
- in_ready  output  1  block can accept an operation
- op_sub  input  1  0 = a+b, 1 = a-b
- a  input  WIDTH  first operand
- b  input  WIDTH  second operand
- out_valid  output  1  result and flags are valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  sum or difference, modulo 2^WIDTH
- cout  output  1  carry out of the MSB
- overflow  output  1  signed overflow
- zero  output  1  result equals 0

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - State goes to IDLE.
  - in_ready=1 once reset is released.
  - out_valid=0, result=0, cout=0, overflow=0, zero=0.
  - Bit counter, shift registers and carry flop all go to 0.
- States: IDLE, RUN, DONE.
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
- IDLE:
  - On an edge with in_valid=1, latch a into the A shift register.
  - Latch b, or ~b when op_sub=1, into the B shift register.
  - Load the carry flop with op_sub, so subtraction is a + ~b + 1.
  - Clear the bit counter and go to RUN.
  - With in_valid=0, stay in IDLE.
- RUN, each edge:
  - sum = A[0]^B[0]^c; next carry = majority(A[0], B[0], c).
  - Shift A and B right by one. Shift sum into the MSB of the result shift register.
  - Increment the counter.
  - On the edge that processes bit WIDTH-1, also:
    - capture the carry into the MSB cell as cin_msb, and the carry out as cout;
    - set overflow = cin_msb ^ cout;
    - set zero = 1 when all WIDTH result bits are 0;
    - load result from the shift register plus the final bit;
    - go to DONE.
- Latency:
  - Acceptance happens at edge T.
  - Bits are processed at edges T+1 through T+WIDTH.
  - out_valid rises after edge T+WIDTH.
- DONE:
  - Hold result and all flags stable while out_valid=1 and out_ready=0.
  - An edge with out_ready=1 goes to IDLE and drops out_valid.
  - result and flags keep their values until the next completion overwrites them.
- Inputs are ignored outside IDLE.
  - a, b, op_sub and in_valid have no effect in RUN or DONE.
  - Changing operands mid-operation does not corrupt the result, because the operands were latched.
- A new operation cannot be accepted on the same edge as the output handshake.
  - Minimum period is WIDTH+2 cycles per operation.
- Flag semantics:
  - For subtraction, cout=1 means no borrow (a >= b unsigned), and cout=0 means borrow.
  - overflow refers to the signed interpretation only.
- Reset mid-operation, in RUN or DONE: abort, return all outputs to reset values, nothing is emitted. The first operation after reset computes correctly.
- out_ready may be held high permanently. The result is then consumed in the first DONE cycle, and out_valid is high for exactly 1 cycle.

Test Plan (all with WIDTH=8):
1. Add 0x3C + 0x0F, out_ready=1.
   - result=0x4B, cout=0, overflow=0, zero=0.
   - out_valid high exactly 8 cycles after the acceptance edge, for 1 cycle.
2. Add 0xFF + 0x01 → result=0x00, cout=1, zero=1, overflow=0.
3. Add 0x7F + 0x01 → result=0x80, cout=0, overflow=1.
4. Subtractions:
   - 0x50 - 0x70 → result=0xE0, cout=0 (borrow), overflow=0.
   - 0x80 - 0x01 → result=0x7F, cout=1, overflow=1.
   - 0x33 - 0x33 → result=0x00, zero=1, cout=1.
5. Backpressure on add 0x12 + 0x34:
   - Hold out_ready=0 for 5 cycles. result stays 0x46 with out_valid=1 and in_ready=0 throughout.
   - Change a and b and assert in_valid during that time. This has no effect.
   - Release out_ready. in_ready returns 1 the next cycle.
6. Reset mid-operation:
   - Start 0xAA + 0x55 and assert rst_n=0 after 4 RUN cycles. Outputs are all 0 and out_valid=0 immediately.
   - After release, 0x01 + 0x02 → result=0x03 with normal latency.
